// File: rtl/alpha_blend_pkg.sv
// ============================================================================
// Module   : alpha_blend_pkg
// Purpose  : Shared types and helpers for the pipelined alpha blender.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alpha_blend_pkg;

  typedef enum logic [1:0] {
    BM_ALPHA   = 2'd0,
    BM_ADD     = 2'd1,
    BM_MULT    = 2'd2,
    BM_REPLACE = 2'd3
  } blend_mode_t;

  typedef enum logic [0:0] {
    FS_IDLE    = 1'b0,
    FS_PENDING = 1'b1
  } frame_state_t;

  // Full-scale value of a DW-bit channel or alpha.
  function automatic int unsigned max_val(input int unsigned dw);
    return (32'd1 << dw) - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/blend_channel.sv
// ============================================================================
// Module   : blend_channel
// Purpose  : Combinational single-channel blend of source and destination.
// Revision : 1.0
// ============================================================================
`default_nettype none

module blend_channel
  import alpha_blend_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] i_s,
  input  logic [DW-1:0] i_d,
  input  logic [DW-1:0] i_a,
  input  logic [1:0]    i_mode,
  output logic [DW-1:0] o_out
);

  localparam logic [DW-1:0] c_max = DW'(max_val(DW));

  logic [2*DW-1:0] w_sa;
  logic [2*DW-1:0] w_dia;
  logic [2*DW-1:0] w_sd;
  logic [DW-1:0]   w_alpha_hi;
  logic [DW-1:0]   w_unused_alpha_lo;
  logic [DW-1:0]   w_sd_hi;
  logic [DW-1:0]   w_unused_sd_lo;
  logic [DW:0]     w_add;

  assign w_sa  = {{DW{1'b0}}, i_s} * {{DW{1'b0}}, i_a};
  assign w_dia = {{DW{1'b0}}, i_d} * {{DW{1'b0}}, c_max - i_a};
  assign w_sd  = {{DW{1'b0}}, i_s} * {{DW{1'b0}}, i_d};

  // s*a + d*(MAX-a) <= MAX*MAX, so the 2*DW-bit sum never wraps.
  assign {w_alpha_hi, w_unused_alpha_lo} = w_sa + w_dia;
  assign {w_sd_hi, w_unused_sd_lo}       = w_sd;
  assign w_add = {1'b0, i_d} + {1'b0, w_sa[2*DW-1:DW]};

  always_comb begin
    o_out = i_s;
    case (blend_mode_t'(i_mode))
      BM_ALPHA: begin
        if (i_a == '0)
          o_out = i_d;
        else if (i_a == c_max)
          o_out = i_s;
        else
          o_out = w_alpha_hi;
      end
      BM_ADD:     o_out = w_add[DW] ? c_max : w_add[DW-1:0];
      BM_MULT:    o_out = w_sd_hi;
      BM_REPLACE: o_out = i_s;
      default:    o_out = i_s;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alpha_blend_pipe.sv
// ============================================================================
// Module   : alpha_blend_pipe
// Purpose  : Pipelined frame-buffer alpha blender with hazard stall and
//            end-of-frame drain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alpha_blend_pipe
  import alpha_blend_pkg::*;
#(
  parameter int CH     = 3,
  parameter int DW     = 8,
  parameter int ADDR_W = 19,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pixel_ready,
  output logic                pixel_busy,
  input  logic [ADDR_W-1:0]   pixel_number,
  input  logic [CH*DW-1:0]    src_pix,
  input  logic [DW-1:0]       a,
  input  logic [1:0]          mode,
  output logic                read,
  output logic [ADDR_W-1:0]   read_addr,
  input  logic [CH*DW-1:0]    read_data,
  output logic                write,
  output logic [ADDR_W-1:0]   write_addr,
  output logic [CH*DW-1:0]    write_data,
  input  logic                frame_ready,
  output logic                o_frame_ready
);

  logic [RD_LAT-1:0]                r_dl_vld;
  logic [RD_LAT-1:0][ADDR_W-1:0]    r_dl_addr;
  logic [RD_LAT-1:0][CH*DW-1:0]     r_dl_src;
  logic [RD_LAT-1:0][DW-1:0]        r_dl_a;
  logic [RD_LAT-1:0][1:0]           r_dl_mode;
  frame_state_t                     r_state;

  logic              w_hit;
  logic              w_accept;
  logic              w_empty_next;
  logic [CH*DW-1:0]  w_blend;

  // Any in-flight pixel to the same address must land before we re-read it.
  always_comb begin
    w_hit = write && (write_addr == pixel_number);
    for (int k = 0; k < RD_LAT; k++) begin
      if (r_dl_vld[k] && (r_dl_addr[k] == pixel_number))
        w_hit = 1'b1;
    end
  end

  assign pixel_busy   = (r_state == FS_PENDING) || (pixel_ready && w_hit);
  assign w_accept     = reset && pixel_ready && !pixel_busy;
  assign read         = w_accept;
  assign read_addr    = pixel_number;
  assign w_empty_next = !w_accept && (r_dl_vld == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dl_vld <= '0;
    end else begin
      r_dl_vld[0] <= w_accept;
      for (int k = 1; k < RD_LAT; k++)
        r_dl_vld[k] <= r_dl_vld[k-1];
    end
  end

  always_ff @(posedge clk) begin
    r_dl_addr[0] <= pixel_number;
    r_dl_src[0]  <= src_pix;
    r_dl_a[0]    <= a;
    r_dl_mode[0] <= mode;
    for (int k = 1; k < RD_LAT; k++) begin
      r_dl_addr[k] <= r_dl_addr[k-1];
      r_dl_src[k]  <= r_dl_src[k-1];
      r_dl_a[k]    <= r_dl_a[k-1];
      r_dl_mode[k] <= r_dl_mode[k-1];
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    blend_channel #(
      .DW (DW)
    ) u_blend_channel (
      .i_s    (r_dl_src[RD_LAT-1][c*DW +: DW]),
      .i_d    (read_data[c*DW +: DW]),
      .i_a    (r_dl_a[RD_LAT-1]),
      .i_mode (r_dl_mode[RD_LAT-1]),
      .o_out  (w_blend[c*DW +: DW])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      write      <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      write <= r_dl_vld[RD_LAT-1];
      if (r_dl_vld[RD_LAT-1]) begin
        write_addr <= r_dl_addr[RD_LAT-1];
        write_data <= w_blend;
      end
    end
  end

  // The pulse is registered, so it fires on the edge before the first empty cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= FS_IDLE;
      o_frame_ready <= 1'b0;
    end else begin
      o_frame_ready <= 1'b0;
      case (r_state)
        FS_IDLE: begin
          if (frame_ready) begin
            if (w_empty_next)
              o_frame_ready <= 1'b1;
            else
              r_state <= FS_PENDING;
          end
        end
        FS_PENDING: begin
          if (w_empty_next) begin
            o_frame_ready <= 1'b1;
            r_state       <= FS_IDLE;
          end
        end
        default: r_state <= FS_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alpha_blend_pipe.sv
// ============================================================================
// Module   : tb_alpha_blend_pipe
// Purpose  : Directed self-checking bench for alpha_blend_pipe with a
//            fixed-latency frame-buffer model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alpha_blend_pipe;

  localparam int CH     = 3;
  localparam int DW     = 8;
  localparam int ADDR_W = 19;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              pixel_ready;
  logic              pixel_busy;
  logic [ADDR_W-1:0] pixel_number;
  logic [CH*DW-1:0]  src_pix;
  logic [DW-1:0]     a;
  logic [1:0]        mode;
  logic              read;
  logic [ADDR_W-1:0] read_addr;
  logic [CH*DW-1:0]  read_data;
  logic              write;
  logic [ADDR_W-1:0] write_addr;
  logic [CH*DW-1:0]  write_data;
  logic              frame_ready;
  logic              o_frame_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alpha_blend_pipe #(
    .CH     (CH),
    .DW     (DW),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pixel_ready   (pixel_ready),
    .pixel_busy    (pixel_busy),
    .pixel_number  (pixel_number),
    .src_pix       (src_pix),
    .a             (a),
    .mode          (mode),
    .read          (read),
    .read_addr     (read_addr),
    .read_data     (read_data),
    .write         (write),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .frame_ready   (frame_ready),
    .o_frame_ready (o_frame_ready)
  );

  // Frame-buffer model: read data appears RD_LAT (=2) cycles after the read cycle.
  logic [CH*DW-1:0]  mem [0:(1<<ADDR_W)-1];
  logic [CH*DW-1:0]  rd_p0, rd_p1;
  logic              pl_we = 1'b0;
  logic [ADDR_W-1:0] pl_addr;
  logic [CH*DW-1:0]  pl_data;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (write) mem[write_addr] <= write_data;
    rd_p0 <= mem[read_addr];
    rd_p1 <= rd_p0;
  end
  assign read_data = rd_p1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] ad, input logic [CH*DW-1:0] d);
    pl_we = 1'b1; pl_addr = ad; pl_data = d;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic drive_pix(input logic [ADDR_W-1:0] ad, input logic [CH*DW-1:0] s,
                           input logic [DW-1:0] al, input logic [1:0] m);
    pixel_ready = 1'b1; pixel_number = ad; src_pix = s; a = al; mode = m;
  endtask

  task automatic test_reset();
    reset = 1'b0; pixel_ready = 1'b0; frame_ready = 1'b0;
    pixel_number = '0; src_pix = '0; a = '0; mode = 2'd0;
    tick(); tick();
    checks++; if (write !== 1'b0) begin failures++; $display("FAIL reset_write: got %b expected 0", write); end
    checks++; if (read !== 1'b0) begin failures++; $display("FAIL reset_read: got %b expected 0", read); end
    checks++; if (pixel_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", pixel_busy); end
    checks++; if (o_frame_ready !== 1'b0) begin failures++; $display("FAIL reset_frame: got %b expected 0", o_frame_ready); end
    checks++; if (write_addr !== '0 || write_data !== '0) begin failures++; $display("FAIL reset_wdata: got %h/%h expected 0/0", write_addr, write_data); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_alpha();
    preload(19'd10, {8'd3, 8'd2, 8'd1});
    drive_pix(19'd10, {8'd192, 8'd64, 8'd128}, 8'd17, 2'd0);
    #1;
    checks++; if (read !== 1'b1 || read_addr !== 19'd10) begin failures++; $display("FAIL alpha_read: got %b/%0d expected 1/10", read, read_addr); end
    tick();
    pixel_ready = 1'b0;
    #1;
    checks++; if (write !== 1'b0) begin failures++; $display("FAIL alpha_write_c1: got %b expected 0", write); end
    tick();
    checks++; if (write !== 1'b0) begin failures++; $display("FAIL alpha_write_c2: got %b expected 0", write); end
    tick();
    checks++; if (write !== 1'b1 || write_addr !== 19'd10) begin failures++; $display("FAIL alpha_write_c3: got %b/%0d expected 1/10", write, write_addr); end
    checks++; if (write_data !== {8'd15, 8'd6, 8'd9}) begin failures++; $display("FAIL alpha_data: got %h expected %h", write_data, {8'd15, 8'd6, 8'd9}); end
    tick();
    checks++; if (write !== 1'b0) begin failures++; $display("FAIL alpha_write_c4: got %b expected 0", write); end
  endtask

  task automatic test_modes();
    logic [CH*DW-1:0] t_dst [5];
    logic [CH*DW-1:0] t_src [5];
    logic [DW-1:0]    t_a   [5];
    logic [1:0]       t_m   [5];
    logic [CH*DW-1:0] t_exp [5];
    t_dst[0] = {8'd0, 8'd170, 8'd255};   t_src[0] = '0;                        t_a[0] = 8'd0;   t_m[0] = 2'd0; t_exp[0] = {8'd0, 8'd170, 8'd255};
    t_dst[1] = {8'd0, 8'd170, 8'd255};   t_src[1] = '0;                        t_a[1] = 8'd255; t_m[1] = 2'd0; t_exp[1] = '0;
    t_dst[2] = {8'd0, 8'd10, 8'd100};    t_src[2] = {8'd0, 8'd100, 8'd200};    t_a[2] = 8'd255; t_m[2] = 2'd1; t_exp[2] = {8'd0, 8'd109, 8'd255};
    t_dst[3] = {8'd255, 8'd50, 8'd128};  t_src[3] = {8'd255, 8'd200, 8'd128};  t_a[3] = 8'd0;   t_m[3] = 2'd2; t_exp[3] = {8'd254, 8'd39, 8'd64};
    t_dst[4] = {8'd9, 8'd9, 8'd9};       t_src[4] = {8'd1, 8'd2, 8'd3};        t_a[4] = 8'd77;  t_m[4] = 2'd3; t_exp[4] = {8'd1, 8'd2, 8'd3};
    for (int i = 0; i < 5; i++) begin
      preload(ADDR_W'(20 + i), t_dst[i]);
      drive_pix(ADDR_W'(20 + i), t_src[i], t_a[i], t_m[i]);
      tick();
      pixel_ready = 1'b0;
      #1;
      for (int w = 0; w < 6 && write !== 1'b1; w++) tick();
      checks++;
      if (write !== 1'b1 || write_addr !== ADDR_W'(20 + i) || write_data !== t_exp[i]) begin
        failures++;
        $display("FAIL mode_vec%0d: got wr=%b addr=%0d data=%h expected 1/%0d/%h", i, write, write_addr, write_data, 20 + i, t_exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_hazard();
    preload(19'd5, {8'd0, 8'd0, 8'd100});
    drive_pix(19'd5, {8'd0, 8'd0, 8'd200}, 8'd128, 2'd0);
    tick();
    drive_pix(19'd5, {8'd0, 8'd0, 8'd50}, 8'd64, 2'd0);
    #1;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (pixel_busy !== 1'b1 || read !== 1'b0) begin
        failures++; $display("FAIL hazard_busy_c%0d: got busy=%b read=%b expected 1/0", c, pixel_busy, read);
      end
      if (c == 3) begin
        checks++;
        if (write !== 1'b1 || write_data !== {8'd0, 8'd0, 8'd149}) begin
          failures++; $display("FAIL hazard_first: got wr=%b data=%h expected 1/000095", write, write_data);
        end
      end
      tick();
    end
    checks++; if (pixel_busy !== 1'b0 || read !== 1'b1) begin failures++; $display("FAIL hazard_release: got busy=%b read=%b expected 0/1", pixel_busy, read); end
    tick();
    pixel_ready = 1'b0;
    #1;
    for (int w = 0; w < 6 && write !== 1'b1; w++) tick();
    checks++;
    if (write !== 1'b1 || write_addr !== 19'd5 || write_data !== {8'd0, 8'd0, 8'd123}) begin
      failures++; $display("FAIL hazard_second: got wr=%b addr=%0d data=%h expected 1/5/00007b", write, write_addr, write_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [CH*DW-1:0] s [3];
    s[0] = 24'h112233; s[1] = 24'h445566; s[2] = 24'h778899;
    for (int i = 0; i < 3; i++) begin
      drive_pix(ADDR_W'(5 + i), s[i], 8'd0, 2'd3);
      #1;
      checks++;
      if (pixel_busy !== 1'b0 || read !== 1'b1) begin
        failures++; $display("FAIL stream_accept%0d: got busy=%b read=%b expected 0/1", i, pixel_busy, read);
      end
      tick();
    end
    pixel_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (write !== 1'b1 || write_addr !== ADDR_W'(5 + i) || write_data !== s[i]) begin
        failures++; $display("FAIL stream_write%0d: got wr=%b addr=%0d data=%h expected 1/%0d/%h", i, write, write_addr, write_data, 5 + i, s[i]);
      end
      tick();
    end
    checks++; if (write !== 1'b0) begin failures++; $display("FAIL stream_end: got %b expected 0", write); end
  endtask

  task automatic test_frame();
    drive_pix(19'd30, 24'hA0A0A0, 8'd0, 2'd3);
    tick();
    drive_pix(19'd31, 24'hB1B1B1, 8'd0, 2'd3);
    tick();
    pixel_ready = 1'b0; frame_ready = 1'b1;
    #1;
    checks++; if (o_frame_ready !== 1'b0) begin failures++; $display("FAIL frame_early: got %b expected 0", o_frame_ready); end
    tick();
    drive_pix(19'd40, 24'h0, 8'd0, 2'd3);
    #1;
    checks++; if (pixel_busy !== 1'b1 || read !== 1'b0) begin failures++; $display("FAIL frame_busy1: got busy=%b read=%b expected 1/0", pixel_busy, read); end
    checks++; if (write !== 1'b1 || write_addr !== 19'd30 || o_frame_ready !== 1'b0) begin failures++; $display("FAIL frame_w1: got wr=%b addr=%0d frm=%b expected 1/30/0", write, write_addr, o_frame_ready); end
    tick();
    frame_ready = 1'b0;
    #1;
    checks++; if (pixel_busy !== 1'b1 || read !== 1'b0) begin failures++; $display("FAIL frame_busy2: got busy=%b read=%b expected 1/0", pixel_busy, read); end
    checks++; if (write !== 1'b1 || write_addr !== 19'd31 || o_frame_ready !== 1'b0) begin failures++; $display("FAIL frame_w2: got wr=%b addr=%0d frm=%b expected 1/31/0", write, write_addr, o_frame_ready); end
    tick();
    pixel_ready = 1'b0;
    #1;
    checks++; if (o_frame_ready !== 1'b1 || write !== 1'b0) begin failures++; $display("FAIL frame_pulse: got frm=%b wr=%b expected 1/0", o_frame_ready, write); end
    tick();
    checks++; if (o_frame_ready !== 1'b0) begin failures++; $display("FAIL frame_single: got %b expected 0", o_frame_ready); end
    frame_ready = 1'b1;
    #1;
    checks++; if (o_frame_ready !== 1'b0) begin failures++; $display("FAIL frame_empty_same: got %b expected 0", o_frame_ready); end
    tick();
    frame_ready = 1'b0;
    checks++; if (o_frame_ready !== 1'b1) begin failures++; $display("FAIL frame_empty_pulse: got %b expected 1", o_frame_ready); end
    tick();
    checks++; if (o_frame_ready !== 1'b0) begin failures++; $display("FAIL frame_empty_end: got %b expected 0", o_frame_ready); end
  endtask

  task automatic test_frame_with_pixel();
    drive_pix(19'd33, 24'h0C0C0C, 8'd0, 2'd3);
    frame_ready = 1'b1;
    #1;
    checks++; if (read !== 1'b1 || pixel_busy !== 1'b0) begin failures++; $display("FAIL fpix_accept: got read=%b busy=%b expected 1/0", read, pixel_busy); end
    tick();
    pixel_ready = 1'b0; frame_ready = 1'b0;
    tick(); tick();
    checks++; if (write !== 1'b1 || write_addr !== 19'd33 || o_frame_ready !== 1'b0) begin failures++; $display("FAIL fpix_write: got wr=%b addr=%0d frm=%b expected 1/33/0", write, write_addr, o_frame_ready); end
    tick();
    checks++; if (o_frame_ready !== 1'b1 || write !== 1'b0) begin failures++; $display("FAIL fpix_pulse: got frm=%b wr=%b expected 1/0", o_frame_ready, write); end
    tick();
    checks++; if (o_frame_ready !== 1'b0) begin failures++; $display("FAIL fpix_end: got %b expected 0", o_frame_ready); end
  endtask

  task automatic test_reset_midop();
    drive_pix(19'd50, 24'hDEADBE, 8'd0, 2'd3);
    tick();
    pixel_ready = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++; if (write !== 1'b0 || read !== 1'b0 || pixel_busy !== 1'b0 || o_frame_ready !== 1'b0) begin failures++; $display("FAIL midrst_outs: got wr=%b rd=%b busy=%b frm=%b expected 0/0/0/0", write, read, pixel_busy, o_frame_ready); end
    checks++; if (write_addr !== '0 || write_data !== '0) begin failures++; $display("FAIL midrst_wdata: got %h/%h expected 0/0", write_addr, write_data); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (write !== 1'b0) begin failures++; $display("FAIL midrst_nowrite%0d: got %b expected 0", c, write); end
    end
    drive_pix(19'd51, {8'd7, 8'd8, 8'd9}, 8'd0, 2'd3);
    tick();
    pixel_ready = 1'b0;
    #1;
    for (int w = 0; w < 6 && write !== 1'b1; w++) tick();
    checks++;
    if (write !== 1'b1 || write_addr !== 19'd51 || write_data !== {8'd7, 8'd8, 8'd9}) begin
      failures++; $display("FAIL midrst_recover: got wr=%b addr=%0d data=%h expected 1/51/070809", write, write_addr, write_data);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alpha();
    test_modes();
    test_hazard();
    test_back_to_back();
    test_frame();
    test_frame_with_pixel();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alpha_blend_pipe.md
Name: alpha_blend_pipe

Overview:
- Pipelined, parametrised successor to the single-pixel alpha blender.
- Accepts one source pixel per cycle (CH channels of DW bits plus alpha) and reads the destination pixel from the frame buffer with a fixed read latency.
- Blends source and destination in one of four modes and writes the result back.
- Sits between the rasteriser output and the frame-buffer port. Stalls on read-after-write address hazards and forwards end-of-frame only after the pipeline drains.

Parameters:
- CH, 3, number of colour channels.
- DW, 8, bits per channel and bits of alpha; MAX = 2^DW-1.
- ADDR_W, 19, pixel address width.
- RD_LAT, 2, frame-buffer read latency in cycles (>=1); read_data is valid exactly RD_LAT cycles after read.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- pixel_ready  in  1  source pixel valid.
- pixel_busy  out  1  source pixel not accepted this cycle.
- pixel_number  in  ADDR_W  destination address.
- src_pix  in  CH*DW  source channels, channel 0 in the LSBs.
- a  in  DW  source alpha.
- mode  in  2  blend mode, sampled with the pixel.
- read  out  1  frame-buffer read strobe.
- read_addr  out  ADDR_W  read address.
- read_data  in  CH*DW  destination pixel.
- write  out  1  frame-buffer write strobe.
- write_addr  out  ADDR_W  write address.
- write_data  out  CH*DW  blended pixel.
- frame_ready  in  1  end-of-frame pulse from upstream.
- o_frame_ready  out  1  end-of-frame pulse to downstream.

Behaviour:
- Reset (reset==0 at a rising edge): all valid bits clear. read, write, o_frame_ready and pixel_busy are 0; write_addr and write_data are 0; the frame-pending flag is clear. Reset mid-operation discards in-flight pixels, and no write is issued for them.
- Accept condition: pixel_ready & ~pixel_busy.
- On accept: read=1 and read_addr=pixel_number in the same cycle (combinational). src, a, mode and address enter a delay line of depth RD_LAT.
- Blend stage: when the delay line output is valid, read_data is combined with the delayed source, and the result is registered.
- Write timing: write=1 with write_addr/write_data RD_LAT+1 cycles after the accept edge. Throughput is 1 pixel per cycle.
- Blend modes, applied per channel (s = source, d = destination):
  - 0 ALPHA: a==0 -> d; a==MAX -> s; else (s*a + d*(MAX-a)) >> DW, truncated. Intermediate is 2*DW bits and cannot overflow.
  - 1 ADD: min(d + ((s*a) >> DW), MAX), saturating.
  - 2 MULT: (s*d) >> DW; alpha ignored.
  - 3 REPLACE: s; alpha ignored.
- Hazard: pixel_busy=1 when pixel_number equals the address of any valid entry in the delay line or blend/write stage. Stall lasts until that entry has been written, so the read returns updated data. Busy is combinational on pixel_number and pixel_ready; the pipeline keeps draining while stalled.
- Frame: frame_ready sets the pending flag. While pending, pixel_busy=1 and nothing is accepted. o_frame_ready pulses for 1 cycle on the first cycle the pipeline is empty (no valid stage, no write this cycle), and pending clears. If frame_ready arrives with the pipeline already empty, o_frame_ready pulses on the next cycle.
- Simultaneous frame_ready and pixel_ready on an unbusy cycle: the pixel is accepted and the frame pulse follows its write.
- A repeated frame_ready while pending is absorbed (single o_frame_ready).

Decomposition:
- Package alpha_blend_pkg: blend_mode_t enum (BM_ALPHA=0, BM_ADD=1, BM_MULT=2, BM_REPLACE=3); function max_val(DW).
- Sub-module blend_channel (combinational, one channel: s, d, a, mode -> out), instantiated CH times by generate.
- The top holds the delay line, hazard compare, output register and frame FSM (IDLE, PENDING).

Test Plan:
- ALPHA, src (128,64,192), a=17, dest (1,2,3), RD_LAT=2: write=1 exactly 3 cycles after accept, write_data=(9,6,15), write_addr=pixel_number.
- ALPHA edge cases, dest (255,170,0), src (0,0,0): with a=0 output is (255,170,0); with a=255 output is (0,0,0) exactly. Then ADD with s=200, d=100, a=255 gives 255 (saturated). MULT with s=128, d=128 gives 64.
- Back-to-back pixels at addresses 5 and 5: pixel_busy high for the second until the first's write cycle. The second read returns the first's result, and the final value equals two sequential blends. Distinct addresses 5,6,7 stream without busy at 1 per cycle.
- frame_ready asserted with 2 pixels in flight: pixel_busy=1, both writes complete, o_frame_ready is a single 1-cycle pulse the cycle after the last write. With an empty pipeline the pulse comes 1 cycle after frame_ready.
- Assert reset (0) one cycle after accepting a pixel: write never asserts for it, all outputs read 0, and after reset is released a new pixel completes normally.
